audio_st_sample_packer: RTL
===========================

Name: audio_st_sample_packer

Overview:
- Upstream feeder for the streaming-to-memory-mapped capture FIFO in the reverb datapath.
- Pairs left/right 16-bit audio samples from the codec receive side into 32-bit words {L,R}.
- Buffers packed words in a small register FIFO and presents them on an Avalon-ST source (valid/ready, ready latency 0).
- Counts words dropped on overflow and flags L/R ordering errors.

Parameters:
- SAMPLE_W, 16, width of one channel sample; packed word width is 2*SAMPLE_W.
- DEPTH, 4, output buffer depth in words; power of 2, minimum 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  packing enable; low forces the pairing FSM idle and ignores sample strobes.
- l_data  in  SAMPLE_W  left sample.
- l_valid  in  1  one-cycle strobe; l_data is valid.
- r_data  in  SAMPLE_W  right sample.
- r_valid  in  1  one-cycle strobe; r_data is valid.
- src_data  out  2*SAMPLE_W  packed word; {L in upper half, R in lower half}.
- src_valid  out  1  src_data is valid.
- src_ready  in  1  downstream accepts; transfer occurs when src_valid & src_ready.
- level  out  log2(DEPTH)+1  number of words held in the buffer.
- drop_count  out  CNT_W  saturating count of packed words dropped because the buffer was full.
- drop_clear  in  1  synchronous clear of drop_count.
- order_err  out  1  sticky flag: L/R ordering violation seen; cleared by drop_clear.

Behaviour:
- Reset: FSM in WAIT_L, held L register = 0, buffer empty, src_valid=0, src_data=0, level=0, drop_count=0, order_err=0.
- FSM states: WAIT_L and HAVE_L.
- WAIT_L, l_valid only: capture l_data, go to HAVE_L.
- WAIT_L, r_valid only: discard r_data, set order_err, stay in WAIT_L.
- WAIT_L, l_valid & r_valid: push {l_data, r_data}, stay in WAIT_L.
- HAVE_L, r_valid only: push {held L, r_data}, go to WAIT_L.
- HAVE_L, l_valid only: overwrite held L, set order_err, stay in HAVE_L.
- HAVE_L, both strobes: push {held L, r_data}, capture the new l_data, stay in HAVE_L.
- enable=0: FSM goes to WAIT_L next cycle and held L is discarded; strobes are ignored; the buffer keeps draining normally.
- Push rules:
  - Push into a non-full buffer writes at the tail.
  - Push while full with no pop: word dropped, drop_count += 1, saturating at all-ones.
  - Push while full with a pop in the same cycle: push accepted; level stays DEPTH.
- Output:
  - src_valid = (level != 0); src_data = head word; both are register-driven, with no combinational path from the sample inputs.
  - Latency: a push in cycle n gives src_valid=1 in cycle n+1 when the buffer was empty.
  - src_data and src_valid hold stable while src_valid & !src_ready.
- Pop and push in the same cycle on a non-empty buffer: level is unchanged and order is preserved.
- drop_clear:
  - drop_count becomes 0 next cycle; order_err is cleared.
  - If a drop coincides with drop_clear, drop_count becomes 1.
  - If an ordering error coincides with drop_clear, order_err becomes 1.
- Pointers are log2(DEPTH)+1 bits with wrap-around. full = (level == DEPTH).
- Asynchronous reset mid-stream: buffer contents are lost and all outputs return to reset values immediately.

Decomposition:
- Shared audio package holds:
  - SAMPLE_W default;
  - a packed-word type {left, right};
  - a function returning the level width from DEPTH.
- One sub-module: audio_st_reg_fifo, the register-based show-ahead FIFO. It has push/pop/full/empty/level and silently ignores a push when full; the parent decides drops.
- The FSM, drop counter and flags stay in the top module.

Test Plan:
- Basic pair, src_ready=1: l 0x1234 at cycle 0, r 0xABCD at cycle 2 -> src_valid=1 at cycle 3 with src_data=0x1234ABCD for one cycle; level returns to 0.
- Simultaneous strobes: l=0x0001 and r=0x0002 in the same cycle, repeated over 3 cycles -> three words 0x00010002 delivered in order; no order_err.
- Ordering errors:
  - r_valid alone in WAIT_L -> order_err=1 and nothing pushed.
  - Then l=0x1111, l=0x2222, r=0x3333 -> a single word 0x22223333.
- Overflow: src_ready=0, push 6 pairs with DEPTH=4 -> level=4, drop_count=2; then src_ready=1 -> the first 4 words drain in order.
- Full with simultaneous push and pop: buffer full, src_ready=1, push in the same cycle -> no drop; level stays 4; the new word appears 4 pops later.
- enable/clear/reset:
  - enable=0 while in HAVE_L, then r_valid -> no push.
  - drop_clear coinciding with a drop -> drop_count=1.
  - reset_n low mid-drain -> src_valid=0 and level=0 asynchronously.

Source files
------------

// File: rtl/audio_st_sample_packer_pkg.sv
// -----------------------------------------------------------------------------
// audio_st_sample_packer_pkg
// Shared definitions for the audio sample packer slice:
//   - SAMPLE_W_DEF      : default width of one channel sample
//   - audio_pair_t      : packed stereo word {left, right} at the default width
//   - pack_state_t      : pairing FSM states
//   - level_width()     : width of a fill-level / pointer field for a given depth
// -----------------------------------------------------------------------------
package audio_st_sample_packer_pkg;

    localparam int SAMPLE_W_DEF = 16;

    // Left channel occupies the upper half of the packed word.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } audio_pair_t;

    typedef enum logic [0:0] {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pack_state_t;

    // A level must represent 0..DEPTH inclusive, hence one bit beyond the index.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_st_reg_fifo.sv
// -----------------------------------------------------------------------------
// audio_st_reg_fifo
// Register-based show-ahead FIFO. The head word is always presented on
// head_data while head_valid is high. A push while full is ignored unless a
// pop happens in the same cycle, in which case the freed slot is reused.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   push, push_data      : write request and word
//   pop                  : consume the head word (ignored when empty)
//   head_data/head_valid : registered head word and its valid flag
//   full, empty          : registered occupancy flags
//   level                : registered number of words held
// -----------------------------------------------------------------------------
module audio_st_reg_fifo
    import audio_st_sample_packer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int IDX_W = LVL_W - 1;
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_pop_s;
    logic             do_push_s;

    // Next-state computation for storage, pointers and the registered head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop_s  = pop && !empty_q;
        // A pop in the same cycle frees a slot, so a full buffer still accepts.
        do_push_s = push && (!full_q || do_pop_s);

        if (do_push_s) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + LVL_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + LVL_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Pointers carry an extra wrap bit, so the difference is the true level.
        level_d = wr_ptr_d - rd_ptr_d;
        valid_d = (level_d != LVL_ZERO);
        empty_d = (level_d == LVL_ZERO);
        full_d  = (level_d == LVL_FULL);

        // Head is taken from next-state storage so a push into an empty
        // buffer is visible on the very next cycle.
        if (valid_d) begin
            head_d = mem_d[rd_ptr_d[IDX_W-1:0]];
        end else begin
            head_d = head_q;
        end
    end

    // State registers for storage, pointers and all outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= LVL_ZERO;
            rd_ptr_q <= LVL_ZERO;
            level_q  <= LVL_ZERO;
            head_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;

endmodule

// File: rtl/audio_st_sample_packer.sv
// -----------------------------------------------------------------------------
// audio_st_sample_packer
// Pairs left/right codec samples into {L,R} words, buffers them in a small
// register FIFO and presents them on an Avalon-ST source (ready latency 0).
// Ports:
//   clock, reset_n            : clock and asynchronous active-low reset
//   enable                    : packing enable; low idles the pairing FSM
//   l_data/l_valid            : left sample and one-cycle strobe
//   r_data/r_valid            : right sample and one-cycle strobe
//   src_data/src_valid/src_ready : Avalon-ST source
//   level                     : words currently buffered
//   drop_count                : saturating count of words lost to overflow
//   drop_clear                : synchronous clear of drop_count and order_err
//   order_err                 : sticky L/R ordering violation flag
// -----------------------------------------------------------------------------
module audio_st_sample_packer
    import audio_st_sample_packer_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16,
    localparam int LVL_W   = level_width(DEPTH),
    localparam int WORD_W  = 2 * SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] l_data,
    input  logic                l_valid,
    input  logic [SAMPLE_W-1:0] r_data,
    input  logic                r_valid,
    output logic [WORD_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic [LVL_W-1:0]    level,
    output logic [CNT_W-1:0]    drop_count,
    input  logic                drop_clear,
    output logic                order_err
);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] SMP_ZERO = {SAMPLE_W{1'b0}};

    pack_state_t         state_q, state_d;
    logic [SAMPLE_W-1:0] held_l_q, held_l_d;
    logic [CNT_W-1:0]    drop_count_q, drop_count_d;
    logic                order_err_q, order_err_d;
    logic                push_req_s;
    pair_t               push_word_s;
    logic                order_set_s;
    logic                drop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    // Pairing FSM next state: decides what (if anything) is pushed this cycle.
    always_comb begin
        state_d     = state_q;
        held_l_d    = held_l_q;
        push_req_s  = 1'b0;
        push_word_s = {WORD_W{1'b0}};
        order_set_s = 1'b0;

        if (!enable) begin
            // Disabled: any half-built pair is abandoned and strobes ignored.
            state_d  = WAIT_L;
            held_l_d = SMP_ZERO;
        end else begin
            case (state_q)
                WAIT_L: begin
                    case ({l_valid, r_valid})
                        2'b10: begin
                            held_l_d = l_data;
                            state_d  = HAVE_L;
                        end
                        2'b01: begin
                            order_set_s = 1'b1;
                        end
                        2'b11: begin
                            push_req_s  = 1'b1;
                            push_word_s = '{left: l_data, right: r_data};
                        end
                        default: begin
                            state_d = WAIT_L;
                        end
                    endcase
                end
                HAVE_L: begin
                    case ({l_valid, r_valid})
                        2'b01: begin
                            push_req_s  = 1'b1;
                            push_word_s = '{left: held_l_q, right: r_data};
                            state_d     = WAIT_L;
                        end
                        2'b10: begin
                            // A second left before any right: keep the newest.
                            held_l_d    = l_data;
                            order_set_s = 1'b1;
                        end
                        2'b11: begin
                            // Right completes the held pair; new left starts the next.
                            push_req_s  = 1'b1;
                            push_word_s = '{left: held_l_q, right: r_data};
                            held_l_d    = l_data;
                        end
                        default: begin
                            state_d = HAVE_L;
                        end
                    endcase
                end
                default: begin
                    state_d  = WAIT_L;
                    held_l_d = SMP_ZERO;
                end
            endcase
        end
    end

    // Drop detection plus next values of the drop counter and ordering flag.
    always_comb begin
        // A full buffer only loses the word when no pop frees a slot.
        drop_s = push_req_s && fifo_full_s && !(src_ready && !fifo_empty_s);

        if (drop_clear) begin
            if (drop_s) begin
                drop_count_d = CNT_ONE;
            end else begin
                drop_count_d = CNT_ZERO;
            end
        end else if (drop_s && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + CNT_ONE;
        end else begin
            drop_count_d = drop_count_q;
        end

        // A new error in the clearing cycle wins over the clear.
        if (drop_clear) begin
            order_err_d = order_set_s;
        end else begin
            order_err_d = order_err_q | order_set_s;
        end
    end

    // Pairing FSM state and held left sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_L;
            held_l_q <= SMP_ZERO;
        end else begin
            state_q  <= state_d;
            held_l_q <= held_l_d;
        end
    end

    // Status registers: drop counter and sticky ordering flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= CNT_ZERO;
            order_err_q  <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            order_err_q  <= order_err_d;
        end
    end

    audio_st_reg_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push_req_s),
        .push_data  (push_word_s),
        .pop        (src_ready),
        .head_data  (src_data),
        .head_valid (src_valid),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .level      (level)
    );

    assign drop_count = drop_count_q;
    assign order_err  = order_err_q;

endmodule
